// File: rtl/tb_seq_pkg.sv
// Shared definitions for the packet test sequencer.
//   - seq_state_e : sequencer FSM states
//   - LFSR_MASK   : Galois feedback mask (shift-right form)
//   - SEED_DEFAULT: LFSR value after reset, and the substitute for a zero seed
//   - next_lfsr() : one step of the 16-bit Galois LFSR
package tb_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRAW_CNT = 3'd1,
    DRAW_LEN = 3'd2,
    SEND     = 3'd3,
    WAIT_RES = 3'd4,
    FINISH   = 3'd5
  } seq_state_e;

  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

  // The bit shifted out decides whether the feedback mask is applied.
  function automatic logic [15:0] next_lfsr(input logic [15:0] cur);
    return cur[0] ? ((cur >> 1) ^ LFSR_MASK) : (cur >> 1);
  endfunction

endpackage

// File: rtl/pkt_test_sequencer_lfsr.sv
// 16-bit Galois LFSR used as the sequencer's random source.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (q returns to SEED)
//   load      : load load_val (a zero value is replaced by SEED)
//   load_val  : seed value
//   adv       : advance one step
//   q         : current LFSR state
module lfsr16_galois
  import tb_seq_pkg::*;
#(
  parameter logic [15:0] SEED = SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        adv,
  output logic [15:0] q
);

  logic [15:0] q_q, q_d;

  // An all-zero state would lock the LFSR, so zero seeds fall back to SEED.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (load_val == 16'd0) ? SEED : load_val;
    end else if (adv) begin
      q_d = next_lfsr(q_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pkt_test_sequencer.sv
// Multi-test packet stimulus sequencer.
// Runs num_test tests; each test draws a random packet count (1..MAX_PKT),
// sends that many packets with random lengths to channel test_idx mod NUM_CH,
// then waits for a checker verdict and updates the pass/fail counters.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, num_test,
//   small_len           : suite request and its settings (sampled when idle)
//   seed_load, seed_val : LFSR seeding, honoured only while idle
//   pkt_valid/pkt_ready : one-hot per-channel packet handshake
//   pkt_len, pkt_last   : shared packet length and last-of-test marker
//   test_idx            : current test index
//   res_valid, res_pass : checker verdict
//   busy, done          : suite in progress / one-cycle completion pulse
//   pass_cnt, fail_cnt  : suite result counters
module pkt_test_sequencer #(
  parameter int          NUM_CH        = 4,
  parameter int          MAX_PKT       = 256,
  parameter int          TEST_W        = 8,
  parameter int          LEN_W         = 6,
  parameter int          SMALL_LEN_MAX = 8,
  parameter logic [15:0] SEED_DEFAULT  = tb_seq_pkg::SEED_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TEST_W-1:0] num_test,
  input  logic              small_len,
  input  logic              seed_load,
  input  logic [15:0]       seed_val,
  output logic [NUM_CH-1:0] pkt_valid,
  input  logic [NUM_CH-1:0] pkt_ready,
  output logic [LEN_W-1:0]  pkt_len,
  output logic              pkt_last,
  output logic [TEST_W-1:0] test_idx,
  input  logic              res_valid,
  input  logic              res_pass,
  output logic              busy,
  output logic              done,
  output logic [TEST_W-1:0] pass_cnt,
  output logic [TEST_W-1:0] fail_cnt
);
  import tb_seq_pkg::*;

  localparam int PW    = $clog2(MAX_PKT);
  localparam int CNT_W = PW + 1;

  seq_state_e        state_q, state_d;
  logic [TEST_W-1:0] num_test_q, num_test_d;
  logic [TEST_W-1:0] test_idx_q, test_idx_d;
  logic [TEST_W-1:0] pass_q, pass_d;
  logic [TEST_W-1:0] fail_q, fail_d;
  logic              small_q, small_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [15:0]       lfsr_q;
  logic              lfsr_load, lfsr_adv, hs, last_test;
  logic [NUM_CH-1:0] sel_oh;

  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W:0] v);
    return v[LEN_W] ? {LEN_W{1'b1}} : v[LEN_W-1:0];
  endfunction

  // Length = low k bits + 1; only the large range can overflow LEN_W bits.
  function automatic logic [LEN_W-1:0] draw_len(input logic [15:0] r, input logic sm);
    logic [LEN_W:0] v;
    if (sm) begin
      v = (LEN_W+1)'(r % 16'(SMALL_LEN_MAX)) + (LEN_W+1)'(1);
    end else begin
      v = {1'b0, r[LEN_W-1:0]} + (LEN_W+1)'(1);
    end
    return sat_len(v);
  endfunction

  // Seed load wins over a same-cycle start, so DRAW_CNT sees the new seed.
  assign lfsr_load = seed_load && (state_q == IDLE);
  assign lfsr_adv  = (state_q == DRAW_CNT) || (state_q == DRAW_LEN);

  lfsr16_galois #(.SEED(SEED_DEFAULT)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (seed_val),
    .adv      (lfsr_adv),
    .q        (lfsr_q)
  );

  assign sel_oh    = NUM_CH'(1) << (test_idx_q & TEST_W'(NUM_CH - 1));
  assign hs        = (state_q == SEND) && (|(sel_oh & pkt_ready));
  assign last_test = (test_idx_q == num_test_q - TEST_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = (num_test == '0) ? FINISH : DRAW_CNT;
      DRAW_CNT: state_d = DRAW_LEN;
      DRAW_LEN: state_d = SEND;
      SEND:     if (hs) state_d = (rem_q == CNT_W'(1)) ? WAIT_RES : DRAW_LEN;
      WAIT_RES: if (res_valid) state_d = last_test ? FINISH : DRAW_CNT;
      FINISH:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    num_test_d = num_test_q;
    test_idx_d = test_idx_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    small_d    = small_q;
    rem_d      = rem_q;
    len_d      = len_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          num_test_d = num_test;
          small_d    = small_len;
          test_idx_d = '0;
          pass_d     = '0;
          fail_d     = '0;
        end
      end
      DRAW_CNT: rem_d = CNT_W'(lfsr_q[PW-1:0]) + CNT_W'(1);
      DRAW_LEN: len_d = draw_len(lfsr_q, small_q);
      SEND:     if (hs) rem_d = rem_q - CNT_W'(1);
      WAIT_RES: begin
        if (res_valid) begin
          if (res_pass) pass_d = pass_q + TEST_W'(1);
          else          fail_d = fail_q + TEST_W'(1);
          // On the final test test_idx holds so it reads num_test-1 afterwards.
          if (!last_test) test_idx_d = test_idx_q + TEST_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_test_q <= '0;
      test_idx_q <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      small_q    <= 1'b0;
      rem_q      <= '0;
      len_q      <= '0;
    end else begin
      num_test_q <= num_test_d;
      test_idx_q <= test_idx_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      small_q    <= small_d;
      rem_q      <= rem_d;
      len_q      <= len_d;
    end
  end

  always_comb begin
    pkt_valid = (state_q == SEND) ? sel_oh : '0;
    pkt_last  = (state_q == SEND) && (rem_q == CNT_W'(1));
    busy      = (state_q != IDLE);
    done      = (state_q == FINISH);
  end

  assign pkt_len  = len_q;
  assign test_idx = test_idx_q;
  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;

endmodule

// File: tb/tb_pkt_test_sequencer.sv
module tb_pkt_test_sequencer;
  import tb_seq_pkg::*;

  localparam int NUM_CH        = 4;
  localparam int MAX_PKT       = 256;
  localparam int TEST_W        = 8;
  localparam int LEN_W         = 6;
  localparam int SMALL_LEN_MAX = 8;

  logic              clk = 1'b0;
  logic              rst, start, small_len, seed_load, res_valid, res_pass;
  logic              pkt_last, busy, done;
  logic [TEST_W-1:0] num_test, test_idx, pass_cnt, fail_cnt;
  logic [15:0]       seed_val;
  logic [NUM_CH-1:0] pkt_valid, pkt_ready;
  logic [LEN_W-1:0]  pkt_len;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  pkt_test_sequencer #(
    .NUM_CH(NUM_CH), .MAX_PKT(MAX_PKT), .TEST_W(TEST_W),
    .LEN_W(LEN_W), .SMALL_LEN_MAX(SMALL_LEN_MAX), .SEED_DEFAULT(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_test(num_test),
    .small_len(small_len), .seed_load(seed_load), .seed_val(seed_val),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_len(pkt_len),
    .pkt_last(pkt_last), .test_idx(test_idx), .res_valid(res_valid),
    .res_pass(res_pass), .busy(busy), .done(done),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference packet length straight from the length rules.
  function automatic int exp_len(input logic [15:0] r, input bit sm);
    int v;
    if (sm) begin
      v = (int'(r) % SMALL_LEN_MAX) + 1;
    end else begin
      v = (int'(r) % (1 << LEN_W)) + 1;
      if (v > (1 << LEN_W) - 1) v = (1 << LEN_W) - 1;
    end
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(pkt_valid), 0);
    check({tag, "_len"},   32'(pkt_len),   0);
    check({tag, "_last"},  32'(pkt_last),  0);
    check({tag, "_idx"},   32'(test_idx),  0);
    check({tag, "_busy"},  32'(busy),      0);
    check({tag, "_done"},  32'(done),      0);
    check({tag, "_pass"},  32'(pass_cnt),  0);
    check({tag, "_fail"},  32'(fail_cnt),  0);
  endtask

  // vmode: 0 all pass, 1 alternate starting with fail, 2 random.
  task automatic run_suite(input bit do_load, input logic [15:0] sv, input int nt,
                           input bit sm, input int vmode, input bit bp10, input bit noise);
    int n, waitc, stall, exp_pass, exp_fail, elen;
    bit v;
    logic [NUM_CH-1:0] oh;
    exp_pass = 0;
    exp_fail = 0;
    seed_load = do_load;
    seed_val  = sv;
    start     = 1'b1;
    num_test  = TEST_W'(nt);
    small_len = sm;
    tick();
    start     = 1'b0;
    seed_load = 1'b0;
    num_test  = TEST_W'($urandom);
    small_len = 1'($urandom);
    if (do_load) m_lfsr = (sv == 16'd0) ? SEED_DEFAULT : sv;
    check("busy_start", 32'(busy), 1);
    for (int t = 0; t < nt; t++) begin
      n = (int'(m_lfsr) % MAX_PKT) + 1;
      m_lfsr = next_lfsr(m_lfsr);
      oh = NUM_CH'(1) << (t % NUM_CH);
      for (int p = 0; p < n; p++) begin
        elen = exp_len(m_lfsr, sm);
        m_lfsr = next_lfsr(m_lfsr);
        waitc = 0;
        while (pkt_valid == '0 && waitc < 8) begin
          if (noise) begin
            res_valid = 1'($urandom);
            res_pass  = 1'($urandom);
          end
          tick();
          waitc++;
        end
        res_valid = 1'b0;
        check("gap", 32'(waitc), (p == 0) ? 2 : 1);
        check("valid", 32'(pkt_valid), 32'(oh));
        check("len", 32'(pkt_len), elen);
        check("last", 32'(pkt_last), 32'(p == n - 1));
        check("idx", 32'(test_idx), t);
        if (bp10 && t == 0 && p == 0) stall = 10;
        else if (noise && ($urandom % 4 == 0)) stall = 1 + $urandom % 3;
        else stall = 0;
        for (int s = 0; s < stall; s++) begin
          pkt_ready = NUM_CH'($urandom) & ~oh;
          if (noise) begin
            seed_load = 1'($urandom);
            seed_val  = 16'($urandom);
          end
          tick();
          check("hold_valid", 32'(pkt_valid), 32'(oh));
          check("hold_len", 32'(pkt_len), elen);
          check("hold_last", 32'(pkt_last), 32'(p == n - 1));
        end
        seed_load = 1'b0;
        pkt_ready = noise ? (oh | NUM_CH'($urandom)) : '1;
        tick();
        pkt_ready = '0;
      end
      waitc = noise ? $urandom % 3 : 0;
      for (int w = 0; w < waitc; w++) begin
        check("wait_novalid", 32'(pkt_valid), 0);
        if (noise) begin
          start    = 1'b1;
          num_test = TEST_W'($urandom);
        end
        tick();
        start = 1'b0;
      end
      check("wait_novalid", 32'(pkt_valid), 0);
      case (vmode)
        0:       v = 1'b1;
        1:       v = (t % 2 == 1);
        default: v = 1'($urandom);
      endcase
      res_valid = 1'b1;
      res_pass  = v;
      tick();
      res_valid = 1'b0;
      res_pass  = 1'($urandom);
      if (v) exp_pass++;
      else   exp_fail++;
    end
    check("done_pulse", 32'(done), 1);
    check("busy_finish", 32'(busy), 1);
    check("finish_novalid", 32'(pkt_valid), 0);
    tick();
    check("done_low", 32'(done), 0);
    check("busy_low", 32'(busy), 0);
    check("pass_cnt", 32'(pass_cnt), exp_pass);
    check("fail_cnt", 32'(fail_cnt), exp_fail);
    check("idx_hold", 32'(test_idx), (nt == 0) ? 0 : nt - 1);
    tick();
  endtask

  task automatic reset_mid();
    int cyc;
    num_test  = TEST_W'(4);
    small_len = 1'b0;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    pkt_ready = '1;
    res_valid = 1'b1;
    res_pass  = 1'b1;
    cyc = 0;
    while (!(test_idx == TEST_W'(2) && pkt_valid != '0) && cyc < 3000) begin
      tick();
      cyc++;
    end
    check("rst_reach_send", 32'(cyc < 3000), 1);
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    pkt_ready = '0;
    res_valid = 1'b0;
    check_all_zero("rst_mid");
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_no_done", 32'(done), 0);
      check("rst_no_busy", 32'(busy), 0);
    end
    m_lfsr = SEED_DEFAULT;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; num_test = '0; small_len = 1'b0;
    seed_load = 1'b0; seed_val = '0; pkt_ready = '0;
    res_valid = 1'b0; res_pass = 1'b0;
    m_lfsr = SEED_DEFAULT;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    run_suite(1'b0, 16'h0000, 0, 1'b0, 0, 1'b0, 1'b0);
    run_suite(1'b1, 16'h0001, 3, 1'b0, 0, 1'b0, 1'b0);
    run_suite(1'b1, 16'h1234, 2, 1'b0, 2, 1'b1, 1'b0);
    run_suite(1'b0, 16'h0000, 5, 1'b1, 1, 1'b0, 1'b1);
    run_suite(1'b1, 16'h0000, 2, 1'b0, 2, 1'b0, 1'b1);
    reset_mid();
    run_suite(1'b0, 16'h0000, 1, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_suite(1'($urandom), 16'($urandom), 1 + $urandom % 3, 1'($urandom), 2, 1'b0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
